// File: rtl/bp_resolve_queue_pkg.sv
// Shared types for the branch-prediction resolve queue.
//   pred_src_e  : where F1's prediction came from (fall-through, BTB, RAS)
//   bp_entry_t  : one queued prediction (pc, predicted target, taken, source)
//   bp_state_e  : resolve FSM states
//   link_pc()   : return address of a call (pc + 8, past the delay slot)
//   sat_inc()   : saturating 32-bit increment for the event counters
package bp_resolve_queue_pkg;

    typedef enum logic [1:0] {
        SRC_FALL = 2'd0,
        SRC_BTB  = 2'd1,
        SRC_RAS  = 2'd2,
        SRC_RSVD = 2'd3
    } pred_src_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        pred_src_e   src;
    } bp_entry_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_DS  = 2'd1,
        ST_REDIRECT = 2'd2
    } bp_state_e;

    localparam logic [31:0] LINK_OFFSET = 32'd8;

    function automatic logic [31:0] link_pc(input logic [31:0] pc);
        return pc + LINK_OFFSET;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Bus bundle between fetch (F1), execute, commit and the resolve queue.
//   master : the environment (drives F1 offers, exe resolutions, ext_flush)
//   slave  : bp_resolve_queue (drives enq_ready, RAS controls, redirect,
//            mispredict counters, proto_err)
interface bp_resolve_queue_if;
    logic        f1_valid;
    logic [31:0] f1_pc;
    logic [31:0] f1_pred_target;
    logic        f1_pred_taken;
    logic [1:0]  f1_pred_src;
    logic        enq_ready;

    logic        exe_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_target;
    logic        exe_taken;
    logic        exe_is_call;
    logic        exe_is_ret;
    logic        ext_flush;

    logic        ras_push;
    logic        ras_pop;
    logic        bk_push;
    logic        bk_pop;
    logic        ras_flush;
    logic [31:0] ret_pc_push;
    logic [31:0] bk_ret_pc_push;
    logic [31:0] jrra_pc;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mispred_cnt;
    logic [31:0] ras_mispred_cnt;
    logic        proto_err;

    modport master (
        output f1_valid, f1_pc, f1_pred_target, f1_pred_taken, f1_pred_src,
        output exe_valid, exe_pc, exe_target, exe_taken, exe_is_call, exe_is_ret,
        output ext_flush,
        input  enq_ready, ras_push, ras_pop, bk_push, bk_pop, ras_flush,
        input  ret_pc_push, bk_ret_pc_push, jrra_pc,
        input  redirect_valid, redirect_pc, mispred_cnt, ras_mispred_cnt, proto_err
    );

    modport slave (
        input  f1_valid, f1_pc, f1_pred_target, f1_pred_taken, f1_pred_src,
        input  exe_valid, exe_pc, exe_target, exe_taken, exe_is_call, exe_is_ret,
        input  ext_flush,
        output enq_ready, ras_push, ras_pop, bk_push, bk_pop, ras_flush,
        output ret_pc_push, bk_ret_pc_push, jrra_pc,
        output redirect_valid, redirect_pc, mispred_cnt, ras_mispred_cnt, proto_err
    );
endinterface

// File: rtl/bp_resolve_queue_fifo.sv
// bp_fifo: circular FIFO with synchronous clear.
//   clk      : clock
//   clr_i    : synchronous clear of pointers and count (has priority)
//   push_i   : write wdata_i at tail (ignored when full, even with pop)
//   pop_i    : advance head (ignored when empty)
//   rdata_o  : current head entry (stale while empty)
//   full_o / empty_o : occupancy flags
// Storage is not reset; only the pointers and count are.
module bp_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic clr_i,
    input  logic push_i,
    input  logic pop_i,
    input  T     wdata_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
            if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: holds F1 predictions in order and checks them against
// execute's resolutions. A mispredict waits for the delay slot to resolve,
// then issues a one-cycle fetch redirect that also flushes the queue and
// the RAS. Calls/returns resolved in RUN drive the RAS and its backup.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : bp_resolve_queue_if.slave (F1, exe, flush, RAS, redirect,
//                 counters, proto_err)
//
//   state       | meaning
//   ST_RUN      | normal resolution, mispredict check on every dequeue
//   ST_WAIT_DS  | mispredict seen, waiting for the delay slot to resolve
//   ST_REDIRECT | one cycle: redirect fetch, flush queue and RAS
module bp_resolve_queue
    import bp_resolve_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8
) (
    input logic               clk,
    input logic               resetn,
    bp_resolve_queue_if.slave bus
);
    bp_state_e   state_q, state_d;
    logic [31:0] fix_pc_q, fix_pc_d;
    logic [31:0] mispred_q, mispred_d;
    logic [31:0] ras_mis_q, ras_mis_d;
    logic        proto_err_q, proto_err_d;

    bp_entry_t   head, wentry;
    logic        full, empty, fifo_clr, push, deq, exe_act, mispred;

    assign wentry = '{pc: bus.f1_pc, target: bus.f1_pred_target,
                      taken: bus.f1_pred_taken, src: pred_src_e'(bus.f1_pred_src)};

    bp_fifo #(.DEPTH(QUEUE_DEPTH), .T(bp_entry_t)) u_fifo (
        .clk     (clk),
        .clr_i   (fifo_clr),
        .push_i  (push),
        .pop_i   (deq),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.mispred_cnt     = mispred_q;
    assign bus.ras_mispred_cnt = ras_mis_q;
    assign bus.proto_err       = proto_err_q;

    always_comb begin
        state_d            = state_q;
        fix_pc_d           = fix_pc_q;
        mispred_d          = mispred_q;
        ras_mis_d          = ras_mis_q;
        proto_err_d        = proto_err_q;
        fifo_clr           = !resetn;
        push               = 1'b0;
        deq                = 1'b0;
        exe_act            = 1'b0;
        mispred            = 1'b0;
        bus.enq_ready      = 1'b0;
        bus.ras_push       = 1'b0;
        bus.bk_push        = 1'b0;
        bus.ras_pop        = 1'b0;
        bus.bk_pop         = 1'b0;
        bus.ras_flush      = 1'b0;
        bus.ret_pc_push    = '0;
        bus.bk_ret_pc_push = '0;
        bus.jrra_pc        = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        if (resetn) begin
            bus.enq_ready = !full && (state_q != ST_REDIRECT);
            push          = bus.f1_valid && bus.enq_ready && !bus.ext_flush;
            // exe data is meaningless while the queue is being flushed
            exe_act       = bus.exe_valid && !bus.ext_flush && (state_q != ST_REDIRECT);
            deq           = exe_act && !empty;
            mispred       = (head.taken != bus.exe_taken) ||
                            (head.taken && bus.exe_taken && (head.target != bus.exe_target));

            if (exe_act && (empty || (head.pc != bus.exe_pc) ||
                            (bus.exe_is_call && bus.exe_is_ret)))
                proto_err_d = 1'b1;

            if (bus.ext_flush) begin
                fifo_clr      = 1'b1;
                bus.ras_flush = 1'b1;
                state_d       = ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (deq) begin
                            if (bus.exe_is_call && !bus.exe_is_ret) begin
                                bus.ras_push       = 1'b1;
                                bus.bk_push        = 1'b1;
                                bus.ret_pc_push    = link_pc(bus.exe_pc);
                                bus.bk_ret_pc_push = link_pc(bus.exe_pc);
                            end
                            if (bus.exe_is_ret && !bus.exe_is_call) begin
                                bus.ras_pop = 1'b1;
                                bus.bk_pop  = 1'b1;
                                bus.jrra_pc = bus.exe_pc;
                            end
                            if (mispred) begin
                                state_d   = ST_WAIT_DS;
                                fix_pc_d  = bus.exe_taken ? bus.exe_target : link_pc(bus.exe_pc);
                                mispred_d = sat_inc(mispred_q);
                                if (head.src == SRC_RAS) ras_mis_d = sat_inc(ras_mis_q);
                            end
                        end
                    end
                    ST_WAIT_DS: begin
                        if (deq) state_d = ST_REDIRECT;
                    end
                    ST_REDIRECT: begin
                        bus.redirect_valid = 1'b1;
                        bus.redirect_pc    = fix_pc_q;
                        bus.ras_flush      = 1'b1;
                        fifo_clr           = 1'b1;
                        state_d            = ST_RUN;
                    end
                    default: state_d = ST_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            fix_pc_q    <= '0;
            mispred_q   <= '0;
            ras_mis_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fix_pc_q    <= fix_pc_d;
            mispred_q   <= mispred_d;
            ras_mis_q   <= ras_mis_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Testbench for bp_resolve_queue: directed scenarios with literal
// expectations, then randomized traffic, all shadowed by a queue-based
// reference model compared every cycle on the falling edge.
module tb_bp_resolve_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    bp_resolve_queue_if bif ();

    bp_resolve_queue #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    int n_err    = 0;
    int n_checks = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic [1:0]  src;
    } ent_t;

    ent_t        mq[$];
    int          m_phase = 0;      // 0 running, 1 awaiting delay slot, 2 redirecting
    logic [31:0] m_fix   = '0;
    logic [31:0] m_mis   = '0;
    logic [31:0] m_rmis  = '0;
    logic        m_perr  = 1'b0;

    always @(negedge clk) begin
        logic        e_enq, e_push, e_pop, e_flush, e_rv, act, redir, wrong;
        logic [31:0] e_rpp, e_jr, e_rpc;
        ent_t        h;
        e_enq = 0; e_push = 0; e_pop = 0; e_flush = 0; e_rv = 0; act = 0; redir = 0;
        e_rpp = '0; e_jr = '0; e_rpc = '0;
        if (resetn) begin
            redir = (m_phase == 2);
            e_enq = (mq.size() < DEPTH) && !redir;
            if (bif.ext_flush) e_flush = 1;
            else if (redir) begin
                e_flush = 1; e_rv = 1; e_rpc = m_fix;
            end
            act = bif.exe_valid && !bif.ext_flush && !redir;
            if (act && mq.size() > 0 && m_phase == 0) begin
                if (bif.exe_is_call && !bif.exe_is_ret) begin
                    e_push = 1; e_rpp = bif.exe_pc + 32'd8;
                end
                if (bif.exe_is_ret && !bif.exe_is_call) begin
                    e_pop = 1; e_jr = bif.exe_pc;
                end
            end
        end
        check1 ("m_enq_ready",       bif.enq_ready,       e_enq);
        check1 ("m_ras_push",        bif.ras_push,        e_push);
        check1 ("m_bk_push",         bif.bk_push,         e_push);
        check1 ("m_ras_pop",         bif.ras_pop,         e_pop);
        check1 ("m_bk_pop",          bif.bk_pop,          e_pop);
        check1 ("m_ras_flush",       bif.ras_flush,       e_flush);
        check32("m_ret_pc_push",     bif.ret_pc_push,     e_rpp);
        check32("m_bk_ret_pc_push",  bif.bk_ret_pc_push,  e_rpp);
        check32("m_jrra_pc",         bif.jrra_pc,         e_jr);
        check1 ("m_redirect_valid",  bif.redirect_valid,  e_rv);
        check32("m_redirect_pc",     bif.redirect_pc,     e_rpc);
        check32("m_mispred_cnt",     bif.mispred_cnt,     m_mis);
        check32("m_ras_mispred_cnt", bif.ras_mispred_cnt, m_rmis);
        check1 ("m_proto_err",       bif.proto_err,       m_perr);

        // advance the model to the state after the coming rising edge
        if (!resetn) begin
            mq.delete(); m_phase = 0; m_fix = '0; m_mis = '0; m_rmis = '0; m_perr = 0;
        end else if (bif.ext_flush || redir) begin
            mq.delete(); m_phase = 0;
        end else begin
            if (act) begin
                if (mq.size() == 0) m_perr = 1;
                else begin
                    h = mq.pop_front();
                    if (h.pc != bif.exe_pc || (bif.exe_is_call && bif.exe_is_ret)) m_perr = 1;
                    if (m_phase == 0) begin
                        wrong = bif.exe_taken ? !(h.tk && h.tgt == bif.exe_target) : h.tk;
                        if (wrong) begin
                            m_phase = 1;
                            m_fix   = bif.exe_taken ? bif.exe_target : bif.exe_pc + 32'd8;
                            if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
                            if (h.src == 2'd2 && m_rmis != 32'hFFFF_FFFF) m_rmis = m_rmis + 1;
                        end
                    end else begin
                        m_phase = 2;
                    end
                end
            end
            if (bif.f1_valid && e_enq)
                mq.push_back('{pc: bif.f1_pc, tgt: bif.f1_pred_target,
                               tk: bif.f1_pred_taken, src: bif.f1_pred_src});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bif.f1_valid = 0; bif.f1_pc = '0; bif.f1_pred_target = '0;
        bif.f1_pred_taken = 0; bif.f1_pred_src = 2'd0;
        bif.exe_valid = 0; bif.exe_pc = '0; bif.exe_target = '0;
        bif.exe_taken = 0; bif.exe_is_call = 0; bif.exe_is_ret = 0;
        bif.ext_flush = 0;
    endtask

    task automatic set_f1(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic [1:0] src);
        bif.f1_valid = 1; bif.f1_pc = pc; bif.f1_pred_target = tgt;
        bif.f1_pred_taken = tk; bif.f1_pred_src = src;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic [1:0] src);
        set_f1(pc, tgt, tk, src);
        tick();
        bif.f1_valid = 0;
    endtask

    task automatic set_exe(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic call, input logic ret);
        bif.exe_valid = 1; bif.exe_pc = pc; bif.exe_taken = tk; bif.exe_target = tgt;
        bif.exe_is_call = call; bif.exe_is_ret = ret;
    endtask

    task automatic clr_exe();
        bif.exe_valid = 0; bif.exe_is_call = 0; bif.exe_is_ret = 0;
    endtask

    initial begin
        idle();
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        // reset: offers are refused while resetn is low
        set_f1(32'h0000_0F00, 32'h0, 1'b0, 2'd0);
        @(negedge clk);
        check1("enq_ready_in_reset", bif.enq_ready, 1'b0);
        tick();
        resetn = 1;
        bif.f1_valid = 0;
        @(negedge clk);
        check1 ("enq_ready_after_reset", bif.enq_ready, 1'b1);
        check1 ("redirect_after_reset", bif.redirect_valid, 1'b0);
        check32("mispred_after_reset", bif.mispred_cnt, 32'd0);
        tick();

        // fill to depth, 9th offer must be ignored
        for (int i = 0; i < 9; i++) begin
            set_f1(32'h0000_1000 + 32'(i * 4), 32'h0000_2000, 1'b0, 2'd1);
            if (i == 8) begin
                @(negedge clk);
                check1("enq_ready_full", bif.enq_ready, 1'b0);
            end
            tick();
        end
        bif.f1_valid = 0;
        for (int i = 0; i < 8; i++) begin
            set_exe(32'h0000_1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        clr_exe();
        @(negedge clk);
        check1("proto_err_after_drain", bif.proto_err, 1'b0);
        // the 9th pc would match if it had been accepted
        set_exe(32'h0000_1020, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clr_exe();
        @(negedge clk);
        check1("proto_err_empty_deq", bif.proto_err, 1'b1);
        tick();
        resetn = 0;
        tick();
        resetn = 1;
        @(negedge clk);
        check1("proto_err_cleared", bif.proto_err, 1'b0);
        tick();

        // call / return
        enq(32'h8000_0040, 32'h8000_1000, 1'b1, 2'd1);
        enq(32'h8000_0300, 32'h8000_0048, 1'b1, 2'd2);
        set_exe(32'h8000_0040, 1'b1, 32'h8000_1000, 1'b1, 1'b0);
        @(negedge clk);
        check1 ("call_ras_push", bif.ras_push, 1'b1);
        check1 ("call_bk_push", bif.bk_push, 1'b1);
        check32("call_ret_pc_push", bif.ret_pc_push, 32'h8000_0048);
        check32("call_bk_ret_pc_push", bif.bk_ret_pc_push, 32'h8000_0048);
        tick();
        set_exe(32'h8000_0300, 1'b1, 32'h8000_0048, 1'b0, 1'b1);
        @(negedge clk);
        check1 ("ret_ras_pop", bif.ras_pop, 1'b1);
        check1 ("ret_bk_pop", bif.bk_pop, 1'b1);
        check32("ret_jrra_pc", bif.jrra_pc, 32'h8000_0300);
        check1 ("ret_no_push", bif.ras_push, 1'b0);
        tick();
        clr_exe();

        // direction mispredict with delay slot
        enq(32'h8000_0100, 32'h8000_0180, 1'b0, 2'd1);
        enq(32'h8000_0104, 32'h0, 1'b0, 2'd0);
        set_exe(32'h8000_0100, 1'b1, 32'h8000_0200, 1'b0, 1'b0);
        tick();
        set_exe(32'h8000_0104, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check1("no_redirect_in_ds", bif.redirect_valid, 1'b0);
        tick();
        clr_exe();
        @(negedge clk);
        check1 ("redir_valid", bif.redirect_valid, 1'b1);
        check32("redir_pc", bif.redirect_pc, 32'h8000_0200);
        check1 ("redir_ras_flush", bif.ras_flush, 1'b1);
        check1 ("redir_enq_blocked", bif.enq_ready, 1'b0);
        check32("redir_mispred_cnt", bif.mispred_cnt, 32'd1);
        tick();
        @(negedge clk);
        check1("redir_one_cycle", bif.redirect_valid, 1'b0);
        tick();

        // RAS-sourced target mispredict
        enq(32'h8000_0400, 32'h8000_0048, 1'b1, 2'd2);
        enq(32'h8000_0404, 32'h0, 1'b0, 2'd0);
        set_exe(32'h8000_0400, 1'b1, 32'h8000_0060, 1'b0, 1'b0);
        tick();
        set_exe(32'h8000_0404, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clr_exe();
        @(negedge clk);
        check32("ras_redir_pc", bif.redirect_pc, 32'h8000_0060);
        check32("ras_mispred_cnt", bif.ras_mispred_cnt, 32'd1);
        check32("ras_case_mispred_cnt", bif.mispred_cnt, 32'd2);
        tick();

        // ext_flush while waiting for the delay slot, 3 entries queued
        enq(32'h8000_0500, 32'h0, 1'b0, 2'd1);
        enq(32'h8000_0504, 32'h0, 1'b0, 2'd1);
        enq(32'h8000_0508, 32'h0, 1'b0, 2'd1);
        set_exe(32'h8000_0500, 1'b1, 32'h8000_0600, 1'b0, 1'b0);
        tick();
        clr_exe();
        enq(32'h8000_050C, 32'h0, 1'b0, 2'd1);
        bif.ext_flush = 1;
        set_f1(32'h8000_0700, 32'h0, 1'b0, 2'd0);
        set_exe(32'h8000_0504, 1'b1, 32'h8000_0999, 1'b1, 1'b0);
        @(negedge clk);
        check1("flush_ras_flush", bif.ras_flush, 1'b1);
        check1("flush_no_redirect", bif.redirect_valid, 1'b0);
        check1("flush_no_push", bif.ras_push, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check1("flush_no_redirect_after", bif.redirect_valid, 1'b0);
        tick();
        set_exe(32'h8000_0504, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clr_exe();
        @(negedge clk);
        check1("flush_queue_empty", bif.proto_err, 1'b1);
        check1("flush_still_no_redirect", bif.redirect_valid, 1'b0);
        tick();

        // reset in the middle of a pending redirect
        resetn = 0;
        tick();
        resetn = 1;
        enq(32'h8000_0800, 32'h0, 1'b0, 2'd1);
        enq(32'h8000_0804, 32'h0, 1'b0, 2'd1);
        set_exe(32'h8000_0800, 1'b1, 32'h8000_0900, 1'b0, 1'b0);
        tick();
        clr_exe();
        resetn = 0;
        tick();
        resetn = 1;
        set_exe(32'h8000_0804, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clr_exe();
        @(negedge clk);
        check1("rst_ds_no_redirect", bif.redirect_valid, 1'b0);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            resetn        = ($urandom_range(0, 299) != 0);
            bif.ext_flush = ($urandom_range(0, 59) == 0);
            bif.f1_valid  = 1'($urandom_range(0, 1));
            bif.f1_pc     = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            bif.f1_pred_target = 32'h8000_0000 + ($urandom_range(0, 7) << 4);
            bif.f1_pred_taken  = 1'($urandom_range(0, 1));
            bif.f1_pred_src    = 2'($urandom_range(0, 3));
            bif.exe_valid   = ($urandom_range(0, 9) < 4);
            bif.exe_is_call = ($urandom_range(0, 9) == 0);
            bif.exe_is_ret  = ($urandom_range(0, 9) == 0);
            if (mq.size() > 0) begin
                bif.exe_pc     = ($urandom_range(0, 39) == 0) ? (mq[0].pc ^ 32'h4) : mq[0].pc;
                bif.exe_taken  = ($urandom_range(0, 9) < 8) ? mq[0].tk : !mq[0].tk;
                bif.exe_target = ($urandom_range(0, 9) < 7) ? mq[0].tgt
                                 : 32'h8000_0000 + ($urandom_range(0, 7) << 4);
            end else begin
                bif.exe_pc     = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
                bif.exe_taken  = 1'($urandom_range(0, 1));
                bif.exe_target = 32'h8000_0000 + ($urandom_range(0, 7) << 4);
            end
            tick();
        end

        idle();
        resetn = 1;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/bp_resolve_queue.md
BP_RESOLVE_QUEUE -- requirements
Module: bp_resolve_queue

Interface
REQ-001 Parameter QUEUE_DEPTH, 8, prediction-queue entries; power of two, at least 4.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 f1_valid  in  1  F1 offers one prediction entry per instruction.
REQ-005 f1_pc / f1_pred_target  in  32 each  instruction pc / predicted target.
REQ-006 f1_pred_taken  in  1; f1_pred_src  in  2  source: 0 fall-through, 1 BTB, 2 RAS, 3 reserved.
REQ-007 enq_ready  out  1  entry accepted when f1_valid && enq_ready.
REQ-008 exe_valid  in  1  exe resolves the oldest queued instruction, in order.
REQ-009 exe_pc, exe_target  in  32 each; exe_taken, exe_is_call, exe_is_ret  in  1 each.
REQ-010 ext_flush  in  1  exception/eret flush from commit.
REQ-011 ras_push, ras_pop, bk_push, bk_pop, ras_flush  out  1 each  RAS controls.
REQ-012 ret_pc_push, bk_ret_pc_push, jrra_pc  out  32 each  RAS data.
REQ-013 redirect_valid  out  1; redirect_pc  out  32  fetch redirect.
REQ-014 mispred_cnt, ras_mispred_cnt  out  32 each; proto_err  out  1 sticky.

Function
REQ-015 Queue: circular FIFO, read/write pointers of log2(QUEUE_DEPTH) bits with wrap, count of log2(QUEUE_DEPTH)+1 bits.
REQ-016 enq_ready = (count != QUEUE_DEPTH) && state != REDIRECT; full blocks enqueue even with same-cycle dequeue.
REQ-017 Dequeue on exe_valid with count != 0; no empty bypass; exe_valid with count == 0 sets proto_err, no other effect.
REQ-018 Head pc != exe_pc on dequeue sets proto_err; resolution proceeds on exe data.
REQ-019 Mispredict: head.pred_taken != exe_taken, or both taken and head.pred_target != exe_target.
REQ-020 Dequeue in RUN, exe_is_call: ras_push = bk_push = 1, ret_pc_push = bk_ret_pc_push = exe_pc + 8 (mod 2^32), same cycle combinationally.
REQ-021 Dequeue in RUN, exe_is_ret: ras_pop = bk_pop = 1, jrra_pc = exe_pc, same cycle; is_call and is_ret together sets proto_err, neither asserted.
REQ-022 FSM states RUN, WAIT_DS, REDIRECT; reset to RUN.
REQ-023 RUN + mispredicted dequeue -> WAIT_DS; latch fix target = exe_taken ? exe_target : exe_pc + 8; mispred_cnt += 1; ras_mispred_cnt += 1 if head.pred_src == 2.
REQ-024 WAIT_DS: next dequeue (delay slot) resolves normally, no mispredict check; -> REDIRECT.
REQ-025 REDIRECT (one cycle): redirect_valid = 1, redirect_pc = latched target, ras_flush = 1, queue cleared (pointers, count to 0), enqueue refused; -> RUN.
REQ-026 Counters saturate at 2^32-1.
REQ-027 ext_flush in any state: queue cleared, state RUN, ras_flush = 1 that cycle, redirect_valid = 0, same-cycle enqueue and dequeue discarded, no RAS push/pop.
REQ-028 Outputs other than listed are 0 when not asserted by a rule above.

Reset
REQ-029 resetn low at posedge: pointers, count = 0, state RUN, counters 0, proto_err 0.
REQ-030 During and the cycle after reset: enq_ready 0 during reset, all strobes and redirect_valid 0.
REQ-031 Reset mid-WAIT_DS or mid-REDIRECT discards latched target; no redirect issued afterward.
REQ-032 Queue storage need not be reset; contents unreadable while count = 0.

Structure
REQ-033 Shared package holds pred_src encoding, queue entry struct (pc, target, taken, src), FSM state enum.
REQ-034 Sub-module bp_fifo (parameterised depth/type, synchronous clear) holds storage and pointers; FSM, RAS drive, counters in bp_resolve_queue.
REQ-035 RTL size 120-400 lines total.

Verification
REQ-036 Enqueue 8 entries, none dequeued -> enq_ready 0 after 8th; 9th f1_valid ignored; count 8.
REQ-037 Head pc 0x8000_0100 pred_taken 0, exe_taken 1 target 0x8000_0200, next dequeue -> one cycle later redirect_valid 1, redirect_pc 0x8000_0200, ras_flush 1, count 0, mispred_cnt 1.
REQ-038 exe_is_call at exe_pc 0x8000_0040 -> ras_push, bk_push 1 same cycle, ret_pc_push 0x8000_0048; exe_is_ret at 0x8000_0300 -> ras_pop, bk_pop 1, jrra_pc 0x8000_0300.
REQ-039 RAS-sourced entry (src 2) target 0x8000_0048, exe_target 0x8000_0060 -> ras_mispred_cnt 1, redirect_pc 0x8000_0060.
REQ-040 ext_flush in WAIT_DS with 3 entries -> count 0, state RUN, ras_flush 1, no redirect_valid.
REQ-041 exe_valid with empty queue -> proto_err 1, pointers unchanged; resetn low clears it.
